mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single memory port between the instruction-fetch unit (read-only) and the load/store unit (read/write), replacing direct asynchronous pmem access with a registered request/response handshake. One transaction is outstanding at a time. The LSU has fixed priority, bounded by a streak counter that guarantees IFU forward progress. Sits between IFU/LSU and the memory model; the downstream rdata feeds the load-extract and writeback path.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, 8, write-mask width, passed through unchanged
MAX_LSU_STREAK, 4, max consecutive LSU grants while IFU waits; must be >=1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU read address
ifu_rsp_valid  out  1  IFU read data valid
ifu_rsp_ready  in  1  IFU accepts response
ifu_rdata  out  DATA_W  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1=write, 0=read
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  MASK_W  store byte mask
lsu_rsp_valid  out  1  LSU response (read data or write ack)
lsu_rsp_ready  in  1  LSU accepts response
lsu_rdata  out  DATA_W  LSU read data; 0 for writes
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_W  latched store data
mem_wmask  out  MASK_W  latched mask; 0 for reads
mem_rsp_valid  in  1  memory response
mem_rsp_ready  out  1  arbiter accepts response
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: clk and rst are decided as stated: one clock; reset is synchronous and active-high. Asserting rst at the edge forces state IDLE, owner=LSU, streak=0, and clears all latched fields. Every out-valid/ready is 0 while rst is high. Reset mid-transaction abandons it; no response is delivered.
- FSM states: IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE arbitration (combinational):
  - pick_ifu = ifu_req_valid && (!lsu_req_valid || streak==MAX_LSU_STREAK)
  - pick_lsu = lsu_req_valid && !pick_ifu
  - The winner's *_req_ready is 1; the loser's is 0. Both are 0 in every other state.
- Acceptance edge (IDLE, winner valid):
  - latch addr/wen/wdata/wmask and owner; go to REQ.
  - IFU winner: force wen=0 and wmask=0.
  - LSU read: wmask is latched as 0.
- Streak counter:
  - LSU grant with ifu_req_valid=1: streak+1, saturating at MAX_LSU_STREAK.
  - LSU grant with ifu_req_valid=0: streak=0.
  - IFU grant: streak=0.
- REQ: mem_req_valid=1 with the latched fields held stable. On mem_req_ready, go to WAIT. No timeout.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid, latch rdata (0 if latched wen=1) and go to RESP. Outside WAIT, mem_rsp_ready=0 and mem_rsp_valid is ignored.
- RESP: the owner's *_rsp_valid=1 and *_rdata=latched data; the non-owner sees valid=0 and rdata=0. On the owner's rsp_ready, go to IDLE.
- Latency:
  - Accept at edge N; mem_req_valid rises in cycle N+1.
  - Zero-wait memory (ready and rsp_valid both tied 1): rsp_valid in cycle N+3.
  - Next grant in the cycle after the response handshake.
  - Best-case throughput: one transaction per 4 cycles.
- Simultaneous events:
  - Requests arriving during REQ/WAIT/RESP wait; upstreams hold valid and fields until ready.
  - A requester dropping valid before ready is permitted; it is simply not granted.
- Widths: every datapath field passes through unmodified; the arbiter does no address decode.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state encoding localparams (ST_IDLE=2'd0, ST_REQ=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3)
  - owner encoding (OWN_LSU=1'b0, OWN_IFU=1'b1)
  - default ADDR_W/DATA_W/MASK_W constants
- One natural sub-module: mem_arb_pick, the combinational priority and streak-override selector producing pick_ifu/pick_lsu. The FSM, latches and counter stay in mem_arbiter.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with both req_valid=1 -> all *_ready, *_rsp_valid and mem_req_valid are 0; after release, LSU is granted first.
- IFU single read: ifu_addr=0x80000000, zero-wait memory returns 0xDEADBEEF -> mem_wen=0, mem_wmask=0; ifu_rsp_valid in the 3rd cycle after acceptance with rdata=0xDEADBEEF; lsu_rsp_valid stays 0.
- LSU write: addr=0x80001004, wdata=0x12345678, wmask=0x0F -> these values appear on mem_* through REQ; lsu_rsp_valid with lsu_rdata=0.
- Starvation bound: both valid continuously, MAX_LSU_STREAK=4 -> grant sequence L,L,L,L,I,L,L,L,L,I.
- Backpressure: mem_req_ready low 5 cycles, mem_rsp_valid delayed 3, owner rsp_ready low 2 -> mem fields stay stable throughout, exactly one response, no second grant until the handshake completes.
- Reset mid-WAIT: assert rst while waiting; a late mem_rsp_valid=1 after release -> ignored (mem_rsp_ready=0), no *_rsp_valid, state IDLE.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory arbiter.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MASK_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic OWN_LSU = 1'b0;
  localparam logic OWN_IFU = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority selector: the LSU wins by default, but the IFU takes the port once the
// LSU has been granted MAX_LSU_STREAK times in a row while the IFU was waiting.
module mem_arb_pick #(
  parameter int STREAK_W       = 3,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                ifu_valid_i,
  input  logic                lsu_valid_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                pick_ifu_o,
  output logic                pick_lsu_o
);

  logic streakAtMax;

  assign streakAtMax = (streak_i == STREAK_W'(MAX_LSU_STREAK));

  // The IFU wins when it is alone or when the LSU has used up its streak budget.
  always_comb begin
    pick_ifu_o = ifu_valid_i && (!lsu_valid_i || streakAtMax);
    pick_lsu_o = lsu_valid_i && !pick_ifu_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with a registered request/response handshake.
// One transaction is in flight at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MASK_W         = MASK_W_DEF,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  input  logic              ifu_rsp_ready,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  input  logic              lsu_rsp_ready,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

  logic [1:0]          state_q,  state_d;
  logic                owner_q,  owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                wen_q,    wen_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [MASK_W-1:0]   wmask_q,  wmask_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;

  logic pickIfu;
  logic pickLsu;
  logic ownerRspReady;
  logic inIdle;
  logic inResp;

  mem_arb_pick #(
    .STREAK_W       (STREAK_W),
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_pick (
    .ifu_valid_i (ifu_req_valid),
    .lsu_valid_i (lsu_req_valid),
    .streak_i    (streak_q),
    .pick_ifu_o  (pickIfu),
    .pick_lsu_o  (pickLsu)
  );

  assign ownerRspReady = (owner_q == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  // Next-state logic: grant and latch in IDLE, then walk the memory handshake.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pickIfu) begin
          owner_d  = OWN_IFU;
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          streak_d = '0;
          state_d  = ST_REQ;
        end else if (pickLsu) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wen ? lsu_wmask : '0;
          if (!ifu_req_valid) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (ownerRspReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched transaction fields; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_LSU;
      streak_q <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
    end
  end

  // Handshake outputs are held low while reset is asserted, whatever the state.
  always_comb begin
    inIdle        = !rst && (state_q == ST_IDLE);
    inResp        = !rst && (state_q == ST_RESP);
    ifu_req_ready = inIdle && pickIfu;
    lsu_req_ready = inIdle && pickLsu;
    mem_req_valid = !rst && (state_q == ST_REQ);
    mem_rsp_ready = !rst && (state_q == ST_WAIT);
    ifu_rsp_valid = inResp && (owner_q == OWN_IFU);
    lsu_rsp_valid = inResp && (owner_q == OWN_LSU);
    ifu_rdata     = ifu_rsp_valid ? rdata_q : '0;
    lsu_rdata     = lsu_rsp_valid ? rdata_q : '0;
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, single IFU/LSU transactions,
// starvation bound, backpressure and reset in the middle of a transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .MASK_W         (8),
    .MAX_LSU_STREAK (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rdata     (mem_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance to one time unit after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // All directed steps, in order.
  initial begin
    int  streakModel;
    logic expIfu;

    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 8'h0;
    lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0;

    $display("[TB] reset with both requesters valid");
    applyStimulus();
    applyStimulus();
    checkOutput("rst_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    checkOutput("rst_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
    checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    checkOutput("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    checkOutput("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_lsu_first", 32'(lsu_req_ready), 32'd1);
    checkOutput("post_rst_ifu_loses", 32'(ifu_req_ready), 32'd0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    applyStimulus();

    $display("[TB] IFU single read, zero-wait memory");
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    mem_rdata     = 32'hDEAD_BEEF;
    #1;
    checkOutput("ifu_req_ready", 32'(ifu_req_ready), 32'd1);
    applyStimulus();
    ifu_req_valid = 1'b0;
    #1;
    checkOutput("ifu_mem_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("ifu_mem_addr", mem_addr, 32'h8000_0000);
    checkOutput("ifu_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("ifu_mem_wmask", 32'(mem_wmask), 32'd0);
    applyStimulus();
    checkOutput("ifu_wait_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    checkOutput("ifu_wait_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    applyStimulus();
    checkOutput("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
    checkOutput("ifu_rdata", ifu_rdata, 32'hDEAD_BEEF);
    checkOutput("ifu_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("ifu_lsu_rdata", lsu_rdata, 32'd0);
    applyStimulus();
    checkOutput("ifu_rsp_done", 32'(ifu_rsp_valid), 32'd0);

    $display("[TB] LSU write");
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1004;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h1234_5678;
    lsu_wmask     = 8'h0F;
    mem_rdata     = 32'hCAFE_F00D;
    #1;
    checkOutput("lsu_wr_req_ready", 32'(lsu_req_ready), 32'd1);
    applyStimulus();
    lsu_req_valid = 1'b0;
    #1;
    checkOutput("lsu_wr_mem_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("lsu_wr_mem_addr", mem_addr, 32'h8000_1004);
    checkOutput("lsu_wr_mem_wen", 32'(mem_wen), 32'd1);
    checkOutput("lsu_wr_mem_wdata", mem_wdata, 32'h1234_5678);
    checkOutput("lsu_wr_mem_wmask", 32'(mem_wmask), 32'h0F);
    applyStimulus();
    applyStimulus();
    checkOutput("lsu_wr_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("lsu_wr_rdata_zero", lsu_rdata, 32'd0);
    checkOutput("lsu_wr_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    applyStimulus();

    $display("[TB] starvation bound with both requesters always valid");
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_3000;
    lsu_wen       = 1'b0;
    lsu_wmask     = 8'hFF;
    mem_rdata     = 32'h0000_1111;
    streakModel   = 0;
    for (int i = 0; i < 10; i++) begin
      if (streakModel == 4) begin
        expIfu      = 1'b1;
        streakModel = 0;
      end else begin
        expIfu      = 1'b0;
        streakModel = streakModel + 1;
      end
      #1;
      checkOutput($sformatf("grant%0d_ifu", i), 32'(ifu_req_ready), 32'(expIfu));
      checkOutput($sformatf("grant%0d_lsu", i), 32'(lsu_req_ready), 32'(!expIfu));
      applyStimulus();
      checkOutput($sformatf("grant%0d_addr", i), mem_addr,
                  expIfu ? 32'h8000_0100 : 32'h8000_3000);
      checkOutput($sformatf("grant%0d_wmask", i), 32'(mem_wmask), 32'd0);
      applyStimulus();
      applyStimulus();
      checkOutput($sformatf("grant%0d_ifu_rsp", i), 32'(ifu_rsp_valid), 32'(expIfu));
      checkOutput($sformatf("grant%0d_lsu_rsp", i), 32'(lsu_rsp_valid), 32'(!expIfu));
      applyStimulus();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    applyStimulus();

    $display("[TB] backpressure on request, response and owner");
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    lsu_wen       = 1'b0;
    ifu_req_valid = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    lsu_rsp_ready = 1'b0;
    #1;
    checkOutput("bp_lsu_req_ready", 32'(lsu_req_ready), 32'd1);
    applyStimulus();
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'hFFFF_FFFF;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_req%0d_valid", i), 32'(mem_req_valid), 32'd1);
      checkOutput($sformatf("bp_req%0d_addr", i), mem_addr, 32'h8000_2000);
      checkOutput($sformatf("bp_req%0d_ifu_ready", i), 32'(ifu_req_ready), 32'd0);
      applyStimulus();
    end
    mem_req_ready = 1'b1;
    #1;
    checkOutput("bp_req_accept", 32'(mem_req_valid), 32'd1);
    applyStimulus();
    mem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_wait%0d_rsp_ready", i), 32'(mem_rsp_ready), 32'd1);
      checkOutput($sformatf("bp_wait%0d_lsu_rsp", i), 32'(lsu_rsp_valid), 32'd0);
      checkOutput($sformatf("bp_wait%0d_addr", i), mem_addr, 32'h8000_2000);
      applyStimulus();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0BAD_C0DE;
    #1;
    checkOutput("bp_wait_last", 32'(mem_rsp_ready), 32'd1);
    applyStimulus();
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("bp_resp%0d_valid", i), 32'(lsu_rsp_valid), 32'd1);
      checkOutput($sformatf("bp_resp%0d_rdata", i), lsu_rdata, 32'h0BAD_C0DE);
      checkOutput($sformatf("bp_resp%0d_ifu_ready", i), 32'(ifu_req_ready), 32'd0);
      applyStimulus();
    end
    lsu_rsp_ready = 1'b1;
    #1;
    checkOutput("bp_resp_hs_valid", 32'(lsu_rsp_valid), 32'd1);
    applyStimulus();
    checkOutput("bp_after_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("bp_next_grant_ifu", 32'(ifu_req_ready), 32'd1);
    ifu_req_valid = 1'b0;
    applyStimulus();
    checkOutput("bp_single_rsp", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("bp_idle_no_req", 32'(mem_req_valid), 32'd0);

    $display("[TB] reset while waiting for memory");
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    checkOutput("mid_ifu_req_ready", 32'(ifu_req_ready), 32'd1);
    applyStimulus();
    ifu_req_valid = 1'b0;
    applyStimulus();
    checkOutput("mid_in_wait", 32'(mem_rsp_ready), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    applyStimulus();
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_0055;
    #1;
    checkOutput("mid_late_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    checkOutput("mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("mid_addr_cleared", mem_addr, 32'd0);
    applyStimulus();
    checkOutput("mid_no_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    checkOutput("mid_no_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("mid_still_no_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    mem_rsp_valid = 1'b0;
    lsu_req_valid = 1'b1;
    #1;
    checkOutput("mid_idle_grant", 32'(lsu_req_ready), 32'd1);
    lsu_req_valid = 1'b0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
